// File: rtl/ip_pll_clkgen.sv
`timescale 1ns/1ps
// ip_pll_clkgen: behavioural stand-in for the vendor PLL (50 MHz in -> 100 / 100@180 / 50 / 25 MHz).
// Define IP_PLL_PERIOD_MONITOR_EN to drop lock when the measured input period leaves tolerance.
module ip_pll_clkgen #(
    parameter int IN_PERIOD_NS = 20,
    parameter int LOCK_CYCLES  = 8,
    parameter int TOL_NS       = 1
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    output logic clk_100m,
    output logic clk_100m_180deg,
    output logic clk_50m,
    output logic clk_25m,
    output logic locked
);

    logic        r_locked;
    logic        r_c100;
    logic        r_c50;
    logic        r_c25;
    logic [31:0] r_epoch;
    logic [31:0] w_next_epoch;
    int          r_count;
    time         r_last_t;

    assign w_next_epoch = r_epoch + 32'd1;

    function automatic int meas_period();
        return int'($time - r_last_t);
    endfunction

    function automatic logic period_ok(input int p);
        int dev;
        dev = (p > IN_PERIOD_NS) ? (p - IN_PERIOD_NS) : (IN_PERIOD_NS - p);
        return (dev <= TOL_NS);
    endfunction

    // Sub-edge toggles for one input period; any newer epoch (next edge or reset) cancels them.
    task automatic run_period(input logic [31:0] ep, input int p);
        #(p / 4);
        if (ep == r_epoch) r_c100 <= 1'b0;
        #(p / 2 - p / 4);
        if (ep == r_epoch) begin
            r_c100 <= 1'b1;
            r_c50  <= 1'b0;
        end
        #((3 * p) / 4 - p / 2);
        if (ep == r_epoch) r_c100 <= 1'b0;
    endtask

    task automatic anchor_edge();
        r_epoch <= w_next_epoch;
        r_c100  <= 1'b1;
        r_c50   <= 1'b1;
        fork
            run_period(w_next_epoch, meas_period());
        join_none
    endtask

    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_epoch  <= w_next_epoch;
            r_locked <= 1'b0;
            r_c100   <= 1'b0;
            r_c50    <= 1'b0;
            r_c25    <= 1'b0;
            r_count  <= 0;
            r_last_t <= 0;
        end else begin
            r_last_t <= $time;
            if (r_locked) begin
`ifdef IP_PLL_PERIOD_MONITOR_EN
                if (!period_ok(meas_period())) begin
                    r_epoch  <= w_next_epoch;
                    r_locked <= 1'b0;
                    r_c100   <= 1'b0;
                    r_c50    <= 1'b0;
                    r_c25    <= 1'b0;
                    r_count  <= 1;
                end else begin
                    r_c25 <= ~r_c25;
                    anchor_edge();
                end
`else
                r_c25 <= ~r_c25;
                anchor_edge();
`endif
            end else if (r_count + 1 >= LOCK_CYCLES) begin
                // This edge closes an acquisition window: lock on a good period, else restart here.
                if (period_ok(meas_period())) begin
                    r_locked <= 1'b1;
                    r_c25    <= 1'b1;
                    anchor_edge();
                end else begin
                    r_count <= 1;
                end
            end else begin
                r_count <= r_count + 1;
            end
        end
    end

    assign locked          = r_locked;
    assign clk_100m        = r_c100;
    assign clk_100m_180deg = r_locked & ~r_c100;
    assign clk_50m         = r_c50;
    assign clk_25m         = r_c25;

endmodule

// File: tb/tb_ip_pll_clkgen.sv
`timescale 1ns/1ps
// tb_ip_pll_clkgen: directed and randomized checks of ip_pll_clkgen against a time-based reference model.
module tb_ip_pll_clkgen;

    localparam int IN_P = 20;
    localparam int LOCK = 8;
    localparam int TOL  = 1;

    logic sys_clk;
    logic sys_rst_n;
    logic clk_100m;
    logic clk_100m_180deg;
    logic clk_50m;
    logic clk_25m;
    logic locked;

    int  per = 20;
    int  n_cmp = 0;
    int  n_bad = 0;
    time edges[$];

    ip_pll_clkgen #(
        .IN_PERIOD_NS (IN_P),
        .LOCK_CYCLES  (LOCK),
        .TOL_NS       (TOL)
    ) dut (
        .sys_clk         (sys_clk),
        .sys_rst_n       (sys_rst_n),
        .clk_100m        (clk_100m),
        .clk_100m_180deg (clk_100m_180deg),
        .clk_50m         (clk_50m),
        .clk_25m         (clk_25m),
        .locked          (locked)
    );

    initial begin
        sys_clk = 1'b0;
        forever begin
            #(per / 2) sys_clk = 1'b1;
            #(per - per / 2) sys_clk = 1'b0;
        end
    end

    // Rising-edge times since the latest reset release.
    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) edges.delete();
        else            edges.push_back($time);
    end

    // Expected {locked, clk_100m, clk_100m_180deg, clk_50m, clk_25m} at time t, from the edge history.
    function automatic logic [4:0] model_out(input time t);
        int  cnt;
        bit  lk;
        bit  par;
        bit  ok;
        time last;
        int  lp;
        int  p;
        int  d;
        logic c100;
        logic c50;
        cnt = 0; lk = 0; par = 0; last = 0; lp = 0;
        if (!sys_rst_n) return 5'b0;
        for (int i = 0; i < edges.size(); i++) begin
            if (edges[i] > t) break;
            p  = (i > 0) ? int'(edges[i] - edges[i-1]) : -1000;
            ok = (i > 0) && (p - IN_P >= -TOL) && (p - IN_P <= TOL);
            if (lk) begin
`ifdef IP_PLL_PERIOD_MONITOR_EN
                if (!ok) begin
                    lk  = 0;
                    cnt = 1;
                    continue;
                end
`endif
                last = edges[i];
                lp   = p;
                par  = ~par;
            end else begin
                cnt++;
                if (cnt >= LOCK) begin
                    if (ok) begin
                        lk = 1; last = edges[i]; lp = p; par = 1;
                    end else begin
                        cnt = 1;
                    end
                end
            end
        end
        if (!lk) return 5'b0;
        d    = int'(t - last);
        c100 = (d < lp / 4) || (d >= lp / 2 && d < (3 * lp) / 4);
        c50  = (d < lp / 2);
        return {1'b1, c100, ~c100, c50, par};
    endfunction

    task automatic chk(input string tag, input logic obs, input logic want);
        n_cmp++;
        assert (obs === want) else begin
            n_bad++;
            $error("FAIL %s @%0t: observed %0b expected %0b", tag, $time, obs, want);
        end
    endtask

    task automatic check_all(input string tag);
        logic [4:0] e;
        e = model_out($time);
        chk({tag, ".locked"},   locked,          e[4]);
        chk({tag, ".clk_100m"}, clk_100m,        e[3]);
        chk({tag, ".clk_180"},  clk_100m_180deg, e[2]);
        chk({tag, ".clk_50m"},  clk_50m,         e[1]);
        chk({tag, ".clk_25m"},  clk_25m,         e[0]);
    endtask

    task automatic wait_until(input time t);
        if ($time < t) #(t - $time);
    endtask

    task automatic set_per(input int v);
        @(posedge sys_clk);
        #1;
        per = v;
    endtask

    // Sample at a random offset after a rising edge, steering clear of scheduled toggle instants.
    task automatic sample_rand(input string tag);
        int p;
        int k;
        int lim;
        @(posedge sys_clk);
        #1;
        p   = (edges.size() >= 2) ? int'(edges[edges.size()-1] - edges[edges.size()-2]) : per;
        lim = ((p < per) ? p : per) - 1;
        if (lim < 1) lim = 1;
        do k = $urandom_range(lim, 1);
        while (lim > 3 && (k == p / 4 || k == p / 2 || k == (3 * p) / 4));
        if (k > 1) #(k - 1);
        check_all(tag);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: time limit reached, observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        sys_rst_n = 1'b0;
        #15 check_all("rst_hold0");
        wait_until(395);
        check_all("rst_hold1");
        wait_until(400);
        sys_rst_n = 1'b1;

        wait_until(549);
        check_all("pre_lock");
        chk("pre_lock.locked_const", locked, 1'b0);
        wait_until(551);
        check_all("lock_edge");
        chk("lock_edge.locked_const", locked, 1'b1);
        chk("lock_edge.c100_const", clk_100m, 1'b1);
        chk("lock_edge.c50_const", clk_50m, 1'b1);
        chk("lock_edge.c25_const", clk_25m, 1'b1);
        chk("lock_edge.c180_const", clk_100m_180deg, 1'b0);
        wait_until(556);
        chk("q1.c100_const", clk_100m, 1'b0);
        chk("q1.c180_const", clk_100m_180deg, 1'b1);
        wait_until(561);
        chk("half.c100_const", clk_100m, 1'b1);
        chk("half.c50_const", clk_50m, 1'b0);
        wait_until(566);
        chk("q3.c180_const", clk_100m_180deg, 1'b1);
        wait_until(571);
        chk("next.c25_const", clk_25m, 1'b0);
        check_all("next");
        repeat (4) sample_rand("steady");

        wait_until(703);
        sys_rst_n = 1'b0;
        #1 check_all("rst_mid");
        chk("rst_mid.c100_const", clk_100m, 1'b0);
        chk("rst_mid.locked_const", locked, 1'b0);
        #3 check_all("rst_mid_late");
        wait_until(800);
        sys_rst_n = 1'b1;
        wait_until(949);
        chk("relock_pre.locked_const", locked, 1'b0);
        wait_until(951);
        chk("relock.locked_const", locked, 1'b1);
        check_all("relock");

        for (int b = 0; b < 6; b++) begin
            set_per(19 + int'($urandom_range(2, 0)));
            repeat (2) @(posedge sys_clk);
            repeat (4) sample_rand("jitter");
        end
        set_per(20);
        repeat (2) @(posedge sys_clk);

        set_per(30);
        repeat (2) @(posedge sys_clk);
        @(posedge sys_clk);
        #1;
`ifdef IP_PLL_PERIOD_MONITOR_EN
        chk("p30.locked_const", locked, 1'b0);
`else
        chk("p30.locked_const", locked, 1'b1);
        #7 chk("p30.q1_c100_const", clk_100m, 1'b0);
        #8 chk("p30.half_c100_const", clk_100m, 1'b1);
`endif
        check_all("p30_fixed");
        repeat (4) sample_rand("p30");
        set_per(20);
        repeat (14) sample_rand("p20_back");
        chk("p20_back.locked_const", locked, 1'b1);

        @(posedge sys_clk);
        do k = $urandom_range(14, 1);
        while (k == 5 || k == 10);
        #(k);
        sys_rst_n = 1'b0;
        #1 check_all("rst_rand0");
        repeat (3) begin
            #4 check_all("rst_rand");
        end

        set_per(24);
        repeat (3) @(posedge sys_clk);
        #3 sys_rst_n = 1'b1;
        repeat (20) sample_rand("p24");
        chk("p24.locked_const", locked, 1'b0);
        chk("p24.c100_const", clk_100m, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ip_pll_clkgen.md
Name: ip_pll_clkgen

Overview:
- Behavioural clock-generation model standing in for the vendor PLL in the clocking subsystem.
- Derives four clocks from the 50 MHz board clock: 100 MHz, 100 MHz shifted 180°, 50 MHz and 25 MHz.
- Provides a lock indicator. Intended for simulation; output timing is derived from the measured input period.

Parameters:
- IN_PERIOD_NS, 20, nominal sys_clk period in ns. Used only as the reference for tolerance checking.
- LOCK_CYCLES, 8, number of sys_clk rising edges after reset release before lock is declared (≥2).
- TOL_NS, 1, allowed deviation (ns) of the measured input period from IN_PERIOD_NS.

Ports:
- sys_clk  input  1  reference clock, nominal 50 MHz.
- sys_rst_n  input  1  asynchronous active-low reset.
- clk_100m  output  1  2× sys_clk, rising edges aligned to sys_clk rising edges.
- clk_100m_180deg  output  1  logical complement of clk_100m once locked.
- clk_50m  output  1  1× sys_clk frequency, rising edges aligned to sys_clk rising edges.
- clk_25m  output  1  sys_clk ÷2, 50 % duty cycle.
- locked  output  1  high while the outputs are valid.

Behaviour:
- Reset: while sys_rst_n = 0 (asynchronous), all five outputs are 0. The edge counter and period measurement are cleared, and any pending scheduled toggles are cancelled.
- Acquisition: after reset release, count sys_clk rising edges. Record the time of each edge; the period P is the difference between the last two edges.
- Lock check: on the LOCK_CYCLES-th rising edge, test |P − IN_PERIOD_NS| ≤ TOL_NS.
  - Fail: restart acquisition at that edge (count = 1). Outputs stay 0 and locked stays 0.
  - Pass: lock is declared at that edge.
- On the lock edge, in the same timestep:
  - locked = 1.
  - clk_100m, clk_50m and clk_25m = 1.
  - clk_100m_180deg = 0.
- Locked operation, relative to each subsequent sys_clk rising edge:
  - clk_100m: toggles at +P/4, +P/2, +3P/4 and rises again exactly on the edge.
  - clk_50m: falls at +P/2 and rises on the edge.
  - clk_25m: toggles on every sys_clk rising edge.
- Every edge is re-anchored to the actual sys_clk rising edge, so no drift accumulates.
- clk_100m_180deg always equals ~clk_100m while locked, and 0 while unlocked.
- Reset asserted mid-operation: all outputs go to 0 immediately, and any scheduled edge after reset assertion is suppressed. Re-acquisition takes a full LOCK_CYCLES edges after release.
- Integer-ns resolution. With P = 20, clk_100m half-period = 5 ns, clk_50m half-period = 10 ns, clk_25m half-period = 20 ns.

Optional Feature:
- Macro IP_PLL_PERIOD_MONITOR_EN.
- Defined: every rising edge while locked re-measures P. If |P − IN_PERIOD_NS| > TOL_NS, then on that edge:
  - locked = 0 and all clocks are forced to 0;
  - acquisition restarts with count = 1.
- Not defined: once locked, the block stays locked until reset. P keeps being measured, but deviations never drop lock.

Test Plan:
- 50 MHz sys_clk (20 ns, first rise at 10 ns); sys_rst_n low until 400 ns, then high -> all outputs 0 through 549 ns. At 550 ns (8th rise after release): locked = 1, clk_100m = 1, clk_50m = 1, clk_25m = 1, clk_100m_180deg = 0.
- Locked steady state -> clk_100m period 10 ns with 5 ns high; clk_100m_180deg rises at 555 and 565 ns; clk_50m period 20 ns; clk_25m high from 550 to 570 ns, period 40 ns.
- Assert sys_rst_n = 0 at 703 ns -> all outputs 0 at 703 ns. Release at 800 ns -> relock at 950 ns.
- sys_clk period 24 ns from power-up (TOL_NS = 1) -> locked never asserts and all clocks stay 0.
- With IP_PLL_PERIOD_MONITOR_EN: after lock, switch sys_clk to a 30 ns period -> locked falls at the first 30 ns-spaced edge. Restoring 20 ns -> relock after 8 edges.
- Without the macro, same stimulus -> locked stays 1 and clk_100m tracks P/4 = 7.5 ns (truncated to ns).
